// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port unified memory: Control FSM vs. loader/debug port.
// Fixed-latency req/ack sequencing with bounded loader starvation.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_CPU,
        GRANT_LDR
    } state_t;

    state_t            state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic pick_ldr;
    logic pick_cpu;
    logic wait_sat;

    always_comb begin
        wait_sat = (wait_cnt >= WAIT_W'(MAX_WAIT));
        pick_ldr = ldr_req && (!cpu_req || wait_sat);
        pick_cpu = cpu_req && !pick_ldr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            wait_cnt  <= '0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            ldr_rdata <= '0;
            ldr_ack   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            mem_en  <= 1'b0;

            // Loader starvation counter; the loader's own access window does not count as waiting.
            if (state == IDLE && pick_ldr)
                wait_cnt <= '0;
            else if (ldr_req && state != GRANT_LDR && !wait_sat)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            case (state)
                IDLE: begin
                    if (pick_ldr) begin
                        state     <= GRANT_LDR;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= ldr_we;
                        mem_addr  <= ldr_addr;
                        mem_wdata <= ldr_wdata;
                        lat_cnt   <= LAT_W'(MEM_LAT - 1);
                    end else if (pick_cpu) begin
                        state     <= GRANT_CPU;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        lat_cnt   <= LAT_W'(MEM_LAT - 1);
                    end
                end

                GRANT_CPU, GRANT_LDR: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (state == GRANT_CPU) begin
                            cpu_ack <= 1'b1;
                            if (!mem_we)
                                cpu_rdata <= mem_rdata;
                        end else begin
                            ldr_ack <= 1'b1;
                            if (!mem_we)
                                ldr_rdata <= mem_rdata;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    a_single_ack: assert property (@(posedge clk) disable iff (!reset_n)
        !(cpu_ack && ldr_ack));
    a_en_one_cycle: assert property (@(posedge clk) disable iff (!reset_n)
        mem_en |=> !mem_en);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2, MAX_WAIT=4.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [15:0] cpu_addr, ldr_addr;
    logic [31:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata;
    logic        cpu_ack, ldr_ack;
    logic        mem_en, mem_we, busy;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(32), .MEM_LAT(2), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [15:0] exp_addr [6];
    int          n_en, n_ack;
    bit          seen;

    initial begin
        exp_addr = '{16'h0100, 16'h0100, 16'h0200, 16'h0100, 16'h0100, 16'h0200};

        reset_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
        mem_rdata = 32'hDEADBEEF;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_ldr_ack", ldr_ack, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        reset_n = 1'b1;
        tick();

        // 1: CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        tick();
        check("t1_mem_en", mem_en, 1);
        check("t1_mem_addr", mem_addr, 16'h0010);
        check("t1_mem_we", mem_we, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_en_drop", mem_en, 0);
        check("t1_no_ack_early", cpu_ack, 0);
        tick();
        check("t1_cpu_ack", cpu_ack, 1);
        check("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check("t1_ldr_ack", ldr_ack, 0);
        check("t1_busy_idle", busy, 0);
        cpu_req = 0;
        tick();
        check("t1_ack_one_cycle", cpu_ack, 0);

        // 2: loader read, then loader write leaves ldr_rdata alone
        ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0040; mem_rdata = 32'hA5A5A5A5;
        repeat (3) tick();
        check("t2_rd_ack", ldr_ack, 1);
        check("t2_rd_data", ldr_rdata, 32'hA5A5A5A5);
        ldr_req = 0;
        tick();
        ldr_req = 1; ldr_we = 1; ldr_wdata = 32'h00001234; mem_rdata = 32'h55555555;
        tick();
        check("t2_mem_en", mem_en, 1);
        check("t2_mem_we", mem_we, 1);
        check("t2_mem_wdata", mem_wdata, 32'h00001234);
        check("t2_mem_addr", mem_addr, 16'h0040);
        repeat (2) tick();
        check("t2_wr_ack", ldr_ack, 1);
        check("t2_cpu_ack", cpu_ack, 0);
        check("t2_rdata_held", ldr_rdata, 32'hA5A5A5A5);
        ldr_req = 0; ldr_we = 0;
        tick();

        // 3: simultaneous requests, CPU first; CPU drops so loader follows
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        ldr_req = 1; ldr_addr = 16'h0200;
        tick();
        check("t3_first_en", mem_en, 1);
        check("t3_first_cpu", mem_addr, 16'h0100);
        repeat (2) tick();
        check("t3_cpu_ack", cpu_ack, 1);
        cpu_req = 0;
        tick();
        check("t3_second_en", mem_en, 1);
        check("t3_second_ldr", mem_addr, 16'h0200);
        repeat (2) tick();
        check("t3_ldr_ack", ldr_ack, 1);
        ldr_req = 0;
        tick();

        // 4: both held; grant order CPU CPU LDR CPU CPU LDR
        cpu_req = 1; ldr_req = 1;
        for (int k = 0; k < 6; k++) begin
            seen = 0;
            for (int t = 0; t < 8; t++) begin
                tick();
                if (mem_en) begin
                    seen = 1;
                    break;
                end
            end
            check($sformatf("t4_grant%0d_seen", k), seen, 1);
            check($sformatf("t4_grant%0d_addr", k), mem_addr, exp_addr[k]);
        end
        cpu_req = 0; ldr_req = 0;
        repeat (4) tick();

        // 5: reset mid-access, held request restarts
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0300; mem_rdata = 32'h12345678;
        tick();
        check("t5_mem_en", mem_en, 1);
        tick();
        reset_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_addr", mem_addr, 0);
        check("t5_rst_rdata", cpu_rdata, 0);
        n_ack = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (cpu_ack || ldr_ack || mem_en) n_ack++;
        end
        check("t5_quiet_in_reset", n_ack, 0);
        reset_n = 1'b1;
        tick();
        check("t5_restart_en", mem_en, 1);
        check("t5_restart_addr", mem_addr, 16'h0300);
        repeat (2) tick();
        check("t5_restart_ack", cpu_ack, 1);
        check("t5_restart_rdata", cpu_rdata, 32'h12345678);
        cpu_req = 0;
        tick();

        // 6: request dropped after grant, input changes ignored
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0044; cpu_wdata = 32'hCAFEF00D;
        tick();
        check("t6_mem_en", mem_en, 1);
        check("t6_mem_wdata", mem_wdata, 32'hCAFEF00D);
        cpu_req = 0; cpu_addr = 16'h0099; cpu_wdata = 32'h0;
        tick();
        check("t6_addr_latched", mem_addr, 16'h0044);
        tick();
        check("t6_cpu_ack", cpu_ack, 1);
        check("t6_rdata_held", cpu_rdata, 32'h12345678);
        n_en = 0; n_ack = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (mem_en) n_en++;
            if (cpu_ack) n_ack++;
        end
        check("t6_no_more_en", n_en, 0);
        check("t6_no_more_ack", n_ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
